// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle RISC-V DIV/DIVU/REM/REMU unit using restoring radix-2 division.
// Stalls the front end while computing and strobes valid_o for one cycle in DONE.
module div_sequencer #(
    parameter bit FAST_SPECIAL = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        busy_o,
    output logic        valid_o,
    output logic [31:0] result_o
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, result_q, result_d;
    logic        op_rem_q, op_rem_d, neg_q_q, neg_q_d, neg_r_q, neg_r_d, valid_q, valid_d;
    logic        accept, is_signed, div0, ovf, ge;
    logic [31:0] a_abs, b_abs, rem_nx, quo_nx, spec_res;
    logic [32:0] r_sh, diff;

    always_comb begin
        accept    = rst_n && state_q == IDLE && start_i && funct3_i[2] && !flush_i;
        is_signed = !funct3_i[0];
        div0      = divisor_i == '0;
        ovf       = is_signed && dividend_i == 32'h8000_0000 && divisor_i == 32'hFFFF_FFFF;
        a_abs     = (is_signed && dividend_i[31]) ? -dividend_i : dividend_i;
        b_abs     = (is_signed && divisor_i[31]) ? -divisor_i : divisor_i;
        spec_res  = funct3_i[1] ? (div0 ? dividend_i : 32'h0) : (div0 ? 32'hFFFF_FFFF : 32'h8000_0000);
        // One restoring step: shift the next dividend bit in, subtract if it fits.
        r_sh      = {rem_q, quo_q[31]};
        diff      = r_sh - {1'b0, dvs_q};
        ge        = !diff[32];
        rem_nx    = ge ? diff[31:0] : r_sh[31:0];
        quo_nx    = {quo_q[30:0], ge};
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        op_rem_d  = op_rem_q;
        neg_q_d   = neg_q_q;
        neg_r_d   = neg_r_q;
        result_d  = result_q;
        valid_d   = 1'b0;
        if (state_q == IDLE) begin
            if (accept) begin
                op_rem_d = funct3_i[1];
                // Divide-by-zero keeps the all-ones quotient unsigned-looking.
                neg_q_d  = is_signed && (dividend_i[31] ^ divisor_i[31]) && !div0;
                neg_r_d  = is_signed && dividend_i[31];
                rem_d    = '0;
                quo_d    = a_abs;
                dvs_d    = b_abs;
                cnt_d    = '0;
                if (FAST_SPECIAL && (div0 || ovf)) begin
                    state_d  = DONE;
                    valid_d  = 1'b1;
                    result_d = spec_res;
                end else begin
                    state_d = CALC;
                end
            end
        end else if (state_q == CALC) begin
            if (flush_i) begin
                state_d = IDLE;
            end else begin
                rem_d = rem_nx;
                quo_d = quo_nx;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d  = DONE;
                    valid_d  = 1'b1;
                    result_d = op_rem_q ? (neg_r_q ? -rem_nx : rem_nx) : (neg_q_q ? -quo_nx : quo_nx);
                end
            end
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            op_rem_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            op_rem_q <= op_rem_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
            valid_q  <= valid_d;
            result_q <= result_d;
        end
    end

    assign stall_o  = accept || state_q == CALC;
    assign busy_o   = state_q != IDLE;
    assign valid_o  = valid_q;
    assign result_o = result_q;
endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: drives a fast-special and a full-latency divider with the same stimulus
// and checks timing and results against an arithmetic reference.
module tb_div_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic [2:0]  funct3_i = '0;
    logic [31:0] dividend_i = '0;
    logic [31:0] divisor_i = '0;
    logic        flush_i = 1'b0;
    logic        stall_f, busy_f, valid_f, stall_s, busy_s, valid_s;
    logic [31:0] res_f, res_s;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    div_sequencer #(.FAST_SPECIAL(1'b1)) u_fast (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .funct3_i(funct3_i),
        .dividend_i(dividend_i), .divisor_i(divisor_i), .flush_i(flush_i),
        .stall_o(stall_f), .busy_o(busy_f), .valid_o(valid_f), .result_o(res_f)
    );

    div_sequencer #(.FAST_SPECIAL(1'b0)) u_slow (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .funct3_i(funct3_i),
        .dividend_i(dividend_i), .divisor_i(divisor_i), .flush_i(flush_i),
        .stall_o(stall_s), .busy_o(busy_s), .valid_o(valid_s), .result_o(res_s)
    );

    function automatic logic [31:0] ref_div(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        if (b == 0) return f3[1] ? a : 32'hFFFF_FFFF;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f3[1] ? 32'h0 : 32'h8000_0000;
        if (!f3[0]) return f3[1] ? 32'(sa % sb) : 32'(sa / sb);
        return f3[1] ? a % b : a / b;
    endfunction

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string tag);
        int lat_f, vf_n, vs_n, vf_at, vs_at, sf_n, ss_n, bf_n;
        logic [31:0] rf, rs;
        lat_f = (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 33;
        {vf_n, vs_n, vf_at, vs_at, sf_n, ss_n, bf_n} = '0;
        rf = '0;
        rs = '0;
        @(negedge clk);
        start_i = 1'b1; funct3_i = f3; dividend_i = a; divisor_i = b;
        #1;
        n_cmp++;
        if (stall_f !== 1'b1 || stall_s !== 1'b1) begin
            n_bad++; $display("FAIL %s accept_stall: got f=%b s=%b want 1", tag, stall_f, stall_s);
        end
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (valid_f === 1'b1) begin vf_n++; vf_at = k; rf = res_f; end
            if (valid_s === 1'b1) begin vs_n++; vs_at = k; rs = res_s; end
            sf_n += int'(stall_f === 1'b1);
            ss_n += int'(stall_s === 1'b1);
            bf_n += int'(busy_f === 1'b1);
            @(posedge clk); #1;
        end
        n_cmp++;
        if (vf_n != 1 || vf_at != lat_f) begin
            n_bad++; $display("FAIL %s fast_valid: got %0d strobes at cycle %0d want 1 at %0d", tag, vf_n, vf_at, lat_f);
        end
        n_cmp++;
        if (rf !== exp) begin n_bad++; $display("FAIL %s fast_result: got %h want %h", tag, rf, exp); end
        n_cmp++;
        if (vs_n != 1 || vs_at != 33) begin
            n_bad++; $display("FAIL %s slow_valid: got %0d strobes at cycle %0d want 1 at 33", tag, vs_n, vs_at);
        end
        n_cmp++;
        if (rs !== exp) begin n_bad++; $display("FAIL %s slow_result: got %h want %h", tag, rs, exp); end
        n_cmp++;
        if (sf_n != lat_f - 1) begin n_bad++; $display("FAIL %s fast_stall_cycles: got %0d want %0d", tag, sf_n, lat_f - 1); end
        n_cmp++;
        if (ss_n != 32) begin n_bad++; $display("FAIL %s slow_stall_cycles: got %0d want 32", tag, ss_n); end
        n_cmp++;
        if (bf_n != lat_f) begin n_bad++; $display("FAIL %s fast_busy_cycles: got %0d want %0d", tag, bf_n, lat_f); end
        n_cmp++;
        if (res_f !== exp || res_s !== exp) begin
            n_bad++; $display("FAIL %s result_hold: got f=%h s=%h want %h", tag, res_f, res_s, exp);
        end
    endtask

    task automatic test_reset();
        start_i = 1'b1; funct3_i = 3'b101; dividend_i = 32'd100; divisor_i = 32'd7;
        #23;
        n_cmp++;
        if ({stall_f, busy_f, valid_f, stall_s, busy_s, valid_s} !== 6'b0 || res_f !== 32'h0 || res_s !== 32'h0) begin
            n_bad++; $display("FAIL reset_outputs: got stall=%b busy=%b valid=%b res=%h want all 0", stall_f, busy_f, valid_f, res_f);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        n_cmp++;
        if (busy_f !== 1'b1 || busy_s !== 1'b1) begin
            n_bad++; $display("FAIL first_accept: got busy f=%b s=%b want 1", busy_f, busy_s);
        end
        repeat (40) @(posedge clk);
        #1;
        n_cmp++;
        if (res_f !== 32'd14 || busy_f !== 1'b0) begin
            n_bad++; $display("FAIL first_result: got %h busy=%b want 0000000e busy=0", res_f, busy_f);
        end
    endtask

    task automatic test_directed();
        logic [2:0]  f3[12]  = '{3'b101, 3'b111, 3'b100, 3'b110, 3'b100, 3'b101, 3'b111,
                                 3'b100, 3'b110, 3'b100, 3'b110, 3'b110};
        logic [31:0] a[12]   = '{100, 100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 7, 5, 5,
                                 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'hFFFF_FFF9};
        logic [31:0] b[12]   = '{7, 7, 2, 2, 32'hFFFF_FFFE, 0, 0,
                                 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 32'hFFFF_FFFE};
        logic [31:0] exp[12] = '{14, 2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 5,
                                 32'h8000_0000, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'hFFFF_FFFF};
        for (int i = 0; i < 12; i++) run_op(f3[i], a[i], b[i], exp[i], $sformatf("dir%0d", i));
    endtask

    task automatic test_ignore();
        @(negedge clk);
        start_i = 1'b1; funct3_i = 3'b000; dividend_i = 32'd100; divisor_i = 32'd7;
        #1;
        n_cmp++;
        if (stall_f !== 1'b0) begin n_bad++; $display("FAIL non_div_stall: got %b want 0", stall_f); end
        @(posedge clk); #1;
        n_cmp++;
        if (busy_f !== 1'b0 || busy_s !== 1'b0) begin n_bad++; $display("FAIL non_div_busy: got %b want 0", busy_f); end
        funct3_i = 3'b101; flush_i = 1'b1;
        #1;
        n_cmp++;
        if (stall_f !== 1'b0) begin n_bad++; $display("FAIL flush_start_stall: got %b want 0", stall_f); end
        @(posedge clk); #1;
        n_cmp++;
        if (busy_f !== 1'b0 || busy_s !== 1'b0) begin n_bad++; $display("FAIL flush_start_busy: got %b want 0", busy_f); end
        start_i = 1'b0; flush_i = 1'b0;
    endtask

    task automatic test_busy_start();
        int v_n;
        logic [31:0] r;
        logic done_stall;
        v_n = 0; r = '0; done_stall = 1'b1;
        @(negedge clk);
        start_i = 1'b1; funct3_i = 3'b101; dividend_i = 32'd100; divisor_i = 32'd7;
        @(posedge clk); #1;
        dividend_i = 32'd1000; divisor_i = 32'd3; funct3_i = 3'b100;
        for (int k = 1; k <= 40; k++) begin
            start_i = (k <= 33);
            if (valid_f === 1'b1) begin v_n++; r = res_f; done_stall = stall_f; end
            @(posedge clk); #1;
        end
        start_i = 1'b0;
        n_cmp++;
        if (v_n != 1 || r !== 32'd14) begin n_bad++; $display("FAIL busy_start: got %0d strobes result %h want 1 and 0000000e", v_n, r); end
        n_cmp++;
        if (done_stall !== 1'b0) begin n_bad++; $display("FAIL done_stall: got %b want 0", done_stall); end
    endtask

    task automatic test_flush();
        logic [31:0] prev;
        prev = res_f;
        @(negedge clk);
        start_i = 1'b1; funct3_i = 3'b101; dividend_i = 32'd100; divisor_i = 32'd7;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        @(negedge clk);
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        n_cmp++;
        if (busy_f !== 1'b0 || stall_f !== 1'b0 || valid_f !== 1'b0 || busy_s !== 1'b0) begin
            n_bad++; $display("FAIL flush_idle: got busy=%b stall=%b valid=%b want 0", busy_f, stall_f, valid_f);
        end
        n_cmp++;
        if (res_f !== prev) begin n_bad++; $display("FAIL flush_result: got %h want %h", res_f, prev); end
        run_op(3'b101, 32'd9, 32'd3, 32'd3, "after_flush");
    endtask

    task automatic test_reset_mid();
        int v_n, b_n;
        v_n = 0; b_n = 0;
        @(negedge clk);
        start_i = 1'b1; funct3_i = 3'b101; dividend_i = 32'd100; divisor_i = 32'd7;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({stall_f, busy_f, valid_f, stall_s, busy_s, valid_s} !== 6'b0 || res_f !== 32'h0 || res_s !== 32'h0) begin
            n_bad++; $display("FAIL mid_reset: got stall=%b busy=%b valid=%b res=%h want all 0", stall_f, busy_f, valid_f, res_f);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            v_n += int'(valid_f === 1'b1 || valid_s === 1'b1);
            b_n += int'(busy_f === 1'b1 || busy_s === 1'b1);
        end
        n_cmp++;
        if (v_n != 0 || b_n != 0) begin n_bad++; $display("FAIL post_reset_quiet: got %0d valid %0d busy want 0", v_n, b_n); end
    endtask

    task automatic test_random();
        logic [2:0]  f3;
        logic [31:0] a, b;
        int sel;
        for (int i = 0; i < 24; i++) begin
            f3 = 3'(4 + $urandom_range(0, 3));
            a = $urandom;
            sel = $urandom_range(0, 9);
            b = (sel == 0) ? 32'h0 : (sel == 2) ? 32'($urandom_range(1, 15)) :
                (sel == 3) ? -32'($urandom_range(1, 15)) : $urandom;
            if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            run_op(f3, a, b, ref_div(f3, a, b), $sformatf("rnd%0d", i));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore();
        test_busy_start();
        test_flush();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
